// File: rtl/sweep_pkg.sv
// Shared types and helpers for the multi-channel sweep generator.
package sweep_pkg;

  // Raw encodings of the mode input.
  localparam logic [1:0] MODE_ENC_TRIANGLE = 2'd0;
  localparam logic [1:0] MODE_ENC_SAWTOOTH = 2'd1;
  localparam logic [1:0] MODE_ENC_HOLD     = 2'd2;

  typedef enum logic [1:0] {
    TRIANGLE = MODE_ENC_TRIANGLE,
    SAWTOOTH = MODE_ENC_SAWTOOTH,
    HOLD     = MODE_ENC_HOLD
  } mode_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP1     = 3'd1,
    DOWN    = 3'd2,
    UP2     = 3'd3,
    RAMP    = 3'd4,
    HOLDING = 3'd5,
    FIN     = 3'd6
  } state_t;

  // The reserved encoding behaves exactly like HOLD.
  function automatic mode_t decode_mode(input logic [1:0] enc);
    case (enc)
      MODE_ENC_TRIANGLE: decode_mode = TRIANGLE;
      MODE_ENC_SAWTOOTH: decode_mode = SAWTOOTH;
      default:           decode_mode = HOLD;
    endcase
  endfunction

  // State that opens every period of the given mode.
  function automatic state_t first_state(input mode_t m);
    case (m)
      TRIANGLE: first_state = UP1;
      SAWTOOTH: first_state = RAMP;
      default:  first_state = HOLDING;
    endcase
  endfunction

endpackage

// File: rtl/sweep_sat_step.sv
// One channel's saturating step: value +/- step, clamped to [0, 2^W-1].
module sweep_sat_step
  import sweep_pkg::*;
#(
  parameter int W = 12
) (
  input  logic [W-1:0] val_i,
  input  logic [W-1:0] step_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  logic [W:0] sum;

  // Add with carry-out detection, or subtract with borrow detection.
  always_comb begin
    sum   = {1'b0, val_i} + {1'b0, step_i};
    res_o = sum[W-1:0];
    if (neg_i) begin
      if (val_i < step_i) res_o = '0;
      else                res_o = val_i - step_i;
    end else if (sum[W]) begin
      res_o = '1;
    end
  end

endmodule

// File: rtl/sweep_gen.sv
// Multi-channel triangle / sawtooth / hold sweep generator.
// Handshake: start is a level sampled only in IDLE; busy is high from the
// start edge until the sweep ends; done is a one-cycle pulse (FIN state)
// on normal completion and is never raised by abort.
module sweep_gen
  import sweep_pkg::*;
#(
  parameter int W     = 12,
  parameter int N_CH  = 2,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          mode,
  input  logic [N_CH*W-1:0]   center,
  input  logic [N_CH-1:0]     pol,
  input  logic [W-1:0]        step,
  input  logic [CNT_W-1:0]    seg_len,
  input  logic [CNT_W-1:0]    n_periods,
  output logic [N_CH*W-1:0]   value,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    period_cnt,
  output state_t              dbg_state
);

  // Segment counter is wide enough for a full 4L sawtooth/hold period.
  localparam int PW = CNT_W + 2;

  state_t              state_q, state_d;
  logic [PW-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]    per_q, per_d;
  logic [N_CH*W-1:0]   value_q, value_d;

  // Configuration captured on the start edge.
  mode_t               mode_q;
  logic [N_CH-1:0]     pol_q;
  logic [W-1:0]        step_q;
  logic [CNT_W-1:0]    seg_len_q;
  logic [CNT_W-1:0]    n_per_q;
  logic [N_CH*W-1:0]   center_q;
  logic                zero_q;

  logic                cfg_load;
  logic                degenerate;
  logic [PW-1:0]       seg_limit;
  logic                seg_last;
  logic                seg_neg;
  logic [CNT_W-1:0]    per_next;
  logic [N_CH*W-1:0]   step_res;

  assign cfg_load   = (state_q == IDLE) && start;
  assign degenerate = (seg_len == '0) || (n_periods == '0);
  assign seg_neg    = (state_q == DOWN);
  assign per_next   = per_q + 1'b1;

  // Per-channel saturating adders; polarity flips the segment's direction.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    sweep_sat_step #(.W(W)) u_sat_step (
      .val_i  (value_q[c*W +: W]),
      .step_i (step_q),
      .neg_i  (seg_neg ^ pol_q[c]),
      .res_o  (step_res[c*W +: W])
    );
  end

  // Length of the current segment: L for UP1/UP2, 2L for DOWN, 4L otherwise.
  always_comb begin
    seg_limit = {2'b00, seg_len_q};
    case (state_q)
      DOWN:          seg_limit = {1'b0, seg_len_q, 1'b0};
      RAMP, HOLDING: seg_limit = {seg_len_q, 2'b00};
      default:       seg_limit = {2'b00, seg_len_q};
    endcase
    seg_last = (cnt_q == seg_limit - 1'b1);
  end

  // Next-state, counter and channel-value logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    value_d = value_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          value_d = center;
          cnt_d   = '0;
          per_d   = '0;
          // A zero-length sweep spends one busy cycle, then finishes.
          state_d = degenerate ? HOLDING : first_state(decode_mode(mode));
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        if (abort) begin
          state_d = IDLE;
        end else if (zero_q) begin
          state_d = FIN;
        end else begin
          if (state_q == RAMP && seg_last) value_d = center_q;
          else if (state_q != HOLDING)     value_d = step_res;
          cnt_d = seg_last ? '0 : cnt_q + 1'b1;
          if (seg_last) begin
            case (state_q)
              UP1:  state_d = DOWN;
              DOWN: state_d = UP2;
              default: begin
                per_d   = per_next;
                state_d = (per_next == n_per_q) ? FIN : first_state(mode_q);
              end
            endcase
          end
        end
      end
    endcase
  end

  // FSM, counters and channel values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      value_q <= value_d;
    end
  end

  // Configuration latch, loaded only when a start is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= TRIANGLE;
      pol_q     <= '0;
      step_q    <= '0;
      seg_len_q <= '0;
      n_per_q   <= '0;
      center_q  <= '0;
      zero_q    <= 1'b0;
    end else if (cfg_load) begin
      mode_q    <= decode_mode(mode);
      pol_q     <= pol;
      step_q    <= step;
      seg_len_q <= seg_len;
      n_per_q   <= n_periods;
      center_q  <= center;
      zero_q    <= degenerate;
    end
  end

  assign value      = value_q;
  assign busy       = (state_q != IDLE) && (state_q != FIN);
  assign done       = (state_q == FIN);
  assign period_cnt = per_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sweep_gen.sv
// Directed bench for sweep_gen with hand-computed expected values.
module tb_sweep_gen;
  import sweep_pkg::*;

  localparam int W     = 12;
  localparam int N_CH  = 2;
  localparam int CNT_W = 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic [N_CH*W-1:0] center;
  logic [N_CH-1:0]   pol;
  logic [W-1:0]      step;
  logic [CNT_W-1:0]  seg_len;
  logic [CNT_W-1:0]  n_periods;
  logic [N_CH*W-1:0] value;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  period_cnt;
  state_t            dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  sweep_gen #(.W(W), .N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .center     (center),
    .pol        (pol),
    .step       (step),
    .seg_len    (seg_len),
    .n_periods  (n_periods),
    .value      (value),
    .busy       (busy),
    .done       (done),
    .period_cnt (period_cnt),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n posedges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [1:0] m, input logic [W-1:0] c0, input logic [W-1:0] c1,
                          input logic [N_CH-1:0] p, input logic [W-1:0] s,
                          input logic [CNT_W-1:0] l, input logic [CNT_W-1:0] np,
                          input logic ab);
    mode      = m;
    center    = {c1, c0};
    pol       = p;
    step      = s;
    seg_len   = l;
    n_periods = np;
    start     = 1'b1;
    abort     = ab;
    tick(1);
    start     = 1'b0;
    abort     = 1'b0;
  endtask

  initial begin
    logic [W-1:0] e;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0;
    center = '0; pol = '0; step = '0; seg_len = '0; n_periods = '0;
    tick(2);
    check("rst_value", value, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pcnt", period_cnt, 0);
    rst = 1'b0;
    tick(1);

    // Triangle, 3 periods of 1000 cycles
    do_start(2'd0, 12'h800, 12'h800, 2'b00, 12'd2, 16'd250, 16'd3, 1'b0);
    check("tri_load", value[11:0], 12'h800);
    check("tri_busy", busy, 1);
    tick(1);
    check("tri_first_step", value[11:0], 12'h802);
    tick(249);
    check("tri_peak0", value[11:0], 12'h9F4);
    check("tri_peak1", value[23:12], 12'h9F4);
    tick(500);
    check("tri_trough", value[11:0], 12'h60C);
    tick(250);
    check("tri_p1_end", value[11:0], 12'h800);
    check("tri_p1_cnt", period_cnt, 1);
    tick(1999);
    check("tri_pre_done", done, 0);
    check("tri_pre_busy", busy, 1);
    tick(1);
    check("tri_done", done, 1);
    check("tri_busy_drop", busy, 0);
    check("tri_pcnt3", period_cnt, 3);
    check("tri_end_val", value[11:0], 12'h800);
    tick(1);
    check("tri_done_pulse", done, 0);
    check("tri_hold_val", value[11:0], 12'h800);

    // Polarity: channel 0 mirrored
    do_start(2'd0, 12'h800, 12'h800, 2'b01, 12'd2, 16'd250, 16'd1, 1'b0);
    tick(250);
    check("pol_ch0_trough", value[11:0], 12'h60C);
    check("pol_ch1_peak", value[23:12], 12'h9F4);
    tick(500);
    check("pol_ch0_peak", value[11:0], 12'h9F4);
    check("pol_ch1_trough", value[23:12], 12'h60C);
    tick(250);
    check("pol_done", done, 1);
    check("pol_end0", value[11:0], 12'h800);
    tick(1);

    // Saturation at both rails
    do_start(2'd0, 12'hFF0, 12'h010, 2'b00, 12'd4, 16'd10, 16'd1, 1'b0);
    tick(4);
    check("sat_hi_clamp", value[11:0], 12'hFFF);
    tick(6);
    check("sat_hi_up1", value[11:0], 12'hFFF);
    check("sat_ch1_up1", value[23:12], 12'h038);
    tick(20);
    check("sat_hi_down", value[11:0], 12'hFAF);
    check("sat_lo_clamp", value[23:12], 12'h000);
    tick(10);
    check("sat_hi_up2", value[11:0], 12'hFD7);
    check("sat_lo_up2", value[23:12], 12'h028);
    check("sat_done", done, 1);
    tick(1);

    // Sawtooth: expected queue of channel-0 values for edges 1..32
    for (int k = 1; k <= 32; k++) begin
      e = 12'h100 + W'(k % 16);
      exp_q.push_back(e);
    end
    do_start(2'd1, 12'h100, 12'h200, 2'b00, 12'd1, 16'd4, 16'd2, 1'b0);
    check("saw_load", value[11:0], 12'h100);
    for (int k = 1; k <= 32; k++) begin
      tick(1);
      e = exp_q.pop_front();
      check($sformatf("saw_v%0d", k), value[11:0], e);
      if (k == 15) check("saw_peak1", value[23:12], 12'h20F);
      if (k == 15) check("saw_pcnt0", period_cnt, 0);
      if (k == 16) check("saw_pcnt1", period_cnt, 1);
      if (k == 31) check("saw_busy31", busy, 1);
    end
    check("saw_pcnt2", period_cnt, 2);
    check("saw_done", done, 1);
    tick(1);

    // Abort, with an ignored start while busy
    do_start(2'd0, 12'h800, 12'h800, 2'b00, 12'd2, 16'd250, 16'd3, 1'b0);
    tick(20);
    mode = 2'd1; center = {12'h123, 12'h123}; step = 12'd7; start = 1'b1;
    tick(1);
    start = 1'b0;
    check("busy_start_ignored", value[11:0], 12'h82A);
    tick(29);
    check("abort_pre", value[11:0], 12'h864);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_val", value[11:0], 12'h864);
    tick(3);
    check("abort_no_done", done, 0);
    check("abort_frozen", value[11:0], 12'h864);

    // Start and abort together in IDLE performs a start; reset mid-sweep
    do_start(2'd0, 12'h800, 12'h800, 2'b00, 12'd2, 16'd250, 16'd3, 1'b1);
    check("start_abort_busy", busy, 1);
    tick(10);
    check("sa_val", value[11:0], 12'h814);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_val", value, 0);
    check("rst_mid_busy", busy, 0);
    tick(1);
    rst = 1'b0;
    tick(5);
    check("rst_need_start", busy, 0);
    check("rst_stay_zero", value, 0);

    // Zero segment length and zero periods
    do_start(2'd0, 12'h456, 12'h789, 2'b00, 12'd5, 16'd0, 16'd3, 1'b0);
    check("zl_busy", busy, 1);
    check("zl_no_done", done, 0);
    tick(1);
    check("zl_done", done, 1);
    check("zl_val", value, {12'h789, 12'h456});
    tick(1);
    do_start(2'd0, 12'h321, 12'h654, 2'b00, 12'd5, 16'd8, 16'd0, 1'b0);
    tick(1);
    check("zn_done", done, 1);
    check("zn_val", value, {12'h654, 12'h321});
    tick(1);

    // Hold mode and the reserved encoding
    do_start(2'd2, 12'hABC, 12'h111, 2'b11, 12'd9, 16'd2, 16'd1, 1'b0);
    tick(7);
    check("hold_val", value, {12'h111, 12'hABC});
    check("hold_busy", busy, 1);
    tick(1);
    check("hold_done", done, 1);
    tick(1);
    do_start(2'd3, 12'h222, 12'h333, 2'b00, 12'd9, 16'd1, 16'd1, 1'b0);
    tick(3);
    check("rsv_val", value, {12'h333, 12'h222});
    tick(1);
    check("rsv_done", done, 1);
    tick(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
